// File: rtl/rename_pkg.sv
// Shared rename-stage constants, the free-list state enum and a pointer helper.
package rename_pkg;

  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned NUM_AREGS = 32;
  localparam int unsigned PREG_W    = 6;
  localparam int unsigned FL_DEPTH  = NUM_PREGS - 1;
  localparam int unsigned INIT_FILL = NUM_PREGS - NUM_AREGS;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } rename_state_e;

  // Circular free-list pointer increment; wraps after the last slot.
  function automatic logic [PREG_W-1:0] fl_ptr_inc(input logic [PREG_W-1:0] ptr);
    if (ptr == PREG_W'(FL_DEPTH - 1)) begin
      return '0;
    end
    return ptr + PREG_W'(1);
  endfunction

endpackage

// File: rtl/lowest_set_enc.sv
// Lowest-set-bit priority encoder: index of the least significant set bit plus an any flag.
module lowest_set_enc #(
  parameter int unsigned Width = 64,
  parameter int unsigned IdxW  = 6
) (
  input  logic [Width-1:0] vec_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    // Scan downwards so the lowest set bit is the last assignment.
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IdxW'(i);
      end
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/preg_free_list_ctrl.sv
// Physical-register free list: initial fill, one allocation per cycle, and
// reclaim of ROB-released registers through a pending vector drained lowest-first.
module preg_free_list_ctrl
  import rename_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alloc_req_i,
  output logic                 alloc_valid_o,
  output logic [PREG_W-1:0]    alloc_preg_o,
  output logic                 stall_o,
  input  logic [NUM_PREGS-1:0] retire_mask_i,
  output logic [PREG_W:0]      free_count_o,
  output logic                 init_done_o,
  output logic                 dbl_free_err_o
);

  rename_state_e        state_q, state_d;
  logic [PREG_W-1:0]    init_ptr_q, init_ptr_d;
  logic [PREG_W-1:0]    head_q, head_d;
  logic [PREG_W-1:0]    tail_q, tail_d;
  logic [PREG_W:0]      count_q, count_d;
  logic [NUM_PREGS-1:0] pending_q, pending_d;
  logic [NUM_PREGS-1:0] in_free_q, in_free_d;
  logic                 dbl_q, dbl_d;
  logic [PREG_W-1:0]    fifo_q [FL_DEPTH];

  logic [PREG_W-1:0]    enc_idx;
  logic                 enc_any;
  logic                 pop, drain, init_wr, wr_en;
  logic [PREG_W-1:0]    wr_data;
  logic [NUM_PREGS-1:0] rel, drain_sel;

  lowest_set_enc #(
    .Width (NUM_PREGS),
    .IdxW  (PREG_W)
  ) u_enc (
    .vec_i (pending_q),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  assign alloc_valid_o  = (state_q == StRun) && (count_q != '0);
  assign alloc_preg_o   = fifo_q[head_q];
  assign stall_o        = ~alloc_valid_o;
  assign free_count_o   = count_q;
  assign init_done_o    = (state_q == StRun);
  assign dbl_free_err_o = dbl_q;

  always_comb begin
    pop       = alloc_req_i && alloc_valid_o;
    init_wr   = (state_q == StInit);
    drain     = (state_q == StRun) && enc_any;
    wr_en     = init_wr || drain;
    wr_data   = init_wr ? (PREG_W'(NUM_AREGS) + init_ptr_q) : enc_idx;

    drain_sel = '0;
    if (drain) begin
      drain_sel[enc_idx] = 1'b1;
    end

    // p0 is hard-wired to x0 and never enters the pool.
    rel       = retire_mask_i;
    rel[0]    = 1'b0;
    pending_d = (pending_q & ~drain_sel) | (rel & ~in_free_q & ~pending_q);
    dbl_d     = dbl_q || (|(rel & (in_free_q | pending_q)));

    in_free_d = in_free_q;
    if (pop) begin
      in_free_d[alloc_preg_o] = 1'b0;
    end
    if (wr_en) begin
      in_free_d[wr_data] = 1'b1;
    end

    head_d  = pop ? fl_ptr_inc(head_q) : head_q;
    tail_d  = wr_en ? fl_ptr_inc(tail_q) : tail_q;
    count_d = count_q + (PREG_W + 1)'(wr_en) - (PREG_W + 1)'(pop);

    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (init_wr) begin
      init_ptr_d = init_ptr_q + PREG_W'(1);
      if (init_ptr_q == PREG_W'(INIT_FILL - 1)) begin
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StInit;
      init_ptr_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      in_free_q  <= '0;
      dbl_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      in_free_q  <= in_free_d;
      dbl_q      <= dbl_d;
    end
  end

  // Storage carries no reset; entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      fifo_q[tail_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_preg_free_list_ctrl.sv
// Directed self-checking bench for preg_free_list_ctrl.
module tb_preg_free_list_ctrl;
  import rename_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 alloc_req;
  logic                 alloc_valid;
  logic [PREG_W-1:0]    alloc_preg;
  logic                 stall;
  logic [NUM_PREGS-1:0] retire_mask;
  logic [PREG_W:0]      free_count;
  logic                 init_done;
  logic                 dbl_free_err;

  int n_cmp;
  int n_bad;

  preg_free_list_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .alloc_req_i    (alloc_req),
    .alloc_valid_o  (alloc_valid),
    .alloc_preg_o   (alloc_preg),
    .stall_o        (stall),
    .retire_mask_i  (retire_mask),
    .free_count_o   (free_count),
    .init_done_o    (init_done),
    .dbl_free_err_o (dbl_free_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    alloc_req   = 1'b0;
    retire_mask = '0;
    step(2);

    check("rst_valid", 32'(alloc_valid), 0);
    check("rst_stall", 32'(stall), 1);
    check("rst_count", 32'(free_count), 0);
    check("rst_done", 32'(init_done), 0);
    check("rst_dbl", 32'(dbl_free_err), 0);

    // Initial fill: 32 writes after reset release.
    rst = 1'b0;
    step(31);
    check("fill31_done", 32'(init_done), 0);
    check("fill31_valid", 32'(alloc_valid), 0);
    check("fill31_count", 32'(free_count), 31);
    step(1);
    check("fill_valid", 32'(alloc_valid), 1);
    check("fill_count", 32'(free_count), 32);
    check("fill_done", 32'(init_done), 1);
    check("fill_preg", 32'(alloc_preg), 32);

    // Eight back-to-back allocations.
    alloc_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("alloc8_preg", 32'(alloc_preg), 32 + i);
      step(1);
    end
    alloc_req = 1'b0;
    check("alloc8_count", 32'(free_count), 24);

    // Drain the remaining 24 entries.
    alloc_req = 1'b1;
    for (int i = 0; i < 24; i++) begin
      check("drain_preg", 32'(alloc_preg), 40 + i);
      step(1);
    end
    check("empty_valid", 32'(alloc_valid), 0);
    check("empty_stall", 32'(stall), 1);
    check("empty_count", 32'(free_count), 0);
    step(1);
    alloc_req = 1'b0;
    check("empty_req_count", 32'(free_count), 0);
    check("empty_req_valid", 32'(alloc_valid), 0);

    // Multi-bit release into an empty list: pushes 5, 9, 40 in order.
    retire_mask = '0;
    retire_mask[5]  = 1'b1;
    retire_mask[9]  = 1'b1;
    retire_mask[40] = 1'b1;
    step(1);
    retire_mask = '0;
    check("rel_k1_valid", 32'(alloc_valid), 0);
    check("rel_k1_count", 32'(free_count), 0);
    step(1);
    check("rel_k2_valid", 32'(alloc_valid), 1);
    check("rel_k2_preg", 32'(alloc_preg), 5);
    check("rel_k2_count", 32'(free_count), 1);
    step(1);
    check("rel_k3_count", 32'(free_count), 2);
    step(1);
    check("rel_k4_count", 32'(free_count), 3);
    check("rel_dbl", 32'(dbl_free_err), 0);
    alloc_req = 1'b1;
    check("rel_pop0", 32'(alloc_preg), 5);
    step(1);
    check("rel_pop1", 32'(alloc_preg), 9);
    step(1);
    check("rel_pop2", 32'(alloc_preg), 40);
    step(1);
    alloc_req = 1'b0;
    check("rel_pop_count", 32'(free_count), 0);

    // Seed two entries, then allocate and release one per cycle across the wrap.
    retire_mask[10] = 1'b1;
    retire_mask[11] = 1'b1;
    step(1);
    retire_mask = '0;
    step(2);
    check("seed_count", 32'(free_count), 2);
    alloc_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      retire_mask = '0;
      retire_mask[12 + i] = 1'b1;
      check("steady_preg", 32'(alloc_preg), 10 + i);
      if (i > 0) check("steady_count", 32'(free_count), 1);
      step(1);
    end
    alloc_req   = 1'b0;
    retire_mask = '0;
    step(1);
    check("steady_end_count", 32'(free_count), 2);
    check("steady_end_preg", 32'(alloc_preg), 50);

    // Bit 0 is ignored; releasing a register already free flags a double free.
    retire_mask[0] = 1'b1;
    step(2);
    retire_mask = '0;
    check("bit0_dbl", 32'(dbl_free_err), 0);
    check("bit0_count", 32'(free_count), 2);
    retire_mask[50] = 1'b1;
    step(1);
    retire_mask = '0;
    check("dbl_set", 32'(dbl_free_err), 1);
    step(1);
    check("dbl_count", 32'(free_count), 2);

    // Reset with p3/p7 pending: they are discarded and the refill is 32..63.
    retire_mask[3] = 1'b1;
    retire_mask[7] = 1'b1;
    step(1);
    retire_mask = '0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rerst_dbl", 32'(dbl_free_err), 0);
    check("rerst_count", 32'(free_count), 0);
    check("rerst_done", 32'(init_done), 0);
    step(32);
    check("refill_valid", 32'(alloc_valid), 1);
    check("refill_count", 32'(free_count), 32);
    alloc_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("refill_preg", 32'(alloc_preg), 32 + i);
      step(1);
    end
    alloc_req = 1'b0;
    step(2);
    check("refill_empty_valid", 32'(alloc_valid), 0);
    check("refill_empty_count", 32'(free_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
